// File: rtl/module_bin2bcd.sv
// Signed binary to sign + BCD converter using sequential shift-add-3 (one bit per clock),
// with a registered leading-zero blanking mask for the 7-segment display path.
module module_bin2bcd #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [WIDTH-1:0]      result_i,
    output logic                  busy,
    output logic                  done,
    output logic                  sign_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [DIGITS-1:0]     blank_o
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    // True when DIGITS decimal digits can hold the largest magnitude 2^(WIDTH-1).
    function automatic bit digits_fit(input int w, input int d);
        logic [127:0] p10;
        logic [127:0] p2;
        p10 = 128'd1;
        for (int i = 0; i < d; i++) begin
            p10 = p10 * 128'd10;
        end
        p2 = 128'd1 << (w - 1);
        return p10 > p2;
    endfunction

    generate
        if (!digits_fit(WIDTH, DIGITS)) begin : g_bad_digits
            $error("module_bin2bcd: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              valid_q;
    logic [WIDTH-1:0]  mag_q;
    logic [BW-1:0]     bcd_q;
    logic [CW-1:0]     cnt_q;
    logic              sign_q;
    logic              zero_q;

    logic              start;
    logic [WIDTH-1:0]  mag_d;
    logic [BW-1:0]     bcd_adj;
    logic [DIGITS-1:0] blank_d;

    assign start = valid & ~valid_q;
    // Unsigned magnitude: the most negative value maps onto 2^(WIDTH-1) without overflow.
    assign mag_d = result_i[WIDTH-1] ? (~result_i + WIDTH'(1)) : result_i;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                        (bcd_q[4*gi +: 4] + 4'd3) : bcd_q[4*gi +: 4];
        end

        assign blank_d[0] = 1'b0;
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign blank_d[gi] = ~|bcd_q[BW-1:4*gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sign_o  <= 1'b0;
            bcd_o   <= '0;
            blank_o <= '0;
        end else begin
            valid_q <= valid;
            done    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sign_q  <= result_i[WIDTH-1];
                        zero_q  <= (result_i == '0);
                        mag_q   <= mag_d;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        busy    <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    cnt_q          <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_o   <= bcd_q;
                    sign_o  <= sign_q & ~zero_q;
                    blank_o <= blank_d;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
